// File: rtl/apb_regfile_slave.sv
// APB completer: DEPTH data-width registers, read-only ID at index 0, WAIT programmable wait states.
// Byte-lane write strobes (pstrb port) are present only when APB_PSTRB_EN is defined.
module apb_regfile_slave #(
  parameter int unsigned          ADDRWIDTH = 16,
  parameter int unsigned          DATAWIDTH = 16,
  parameter int unsigned          DEPTH     = 8,
  parameter int unsigned          WAIT      = 0,
  parameter logic [DATAWIDTH-1:0] ID        = 16'hA5B0
) (
  input  logic                   pclk,
  input  logic                   preset,
  input  logic                   psel,
  input  logic                   penable,
  input  logic [ADDRWIDTH-1:0]   paddr,
  input  logic                   pwrite,
  input  logic [DATAWIDTH-1:0]   pwdata,
`ifdef APB_PSTRB_EN
  input  logic [DATAWIDTH/8-1:0] pstrb,
`endif
  output logic [DATAWIDTH-1:0]   prdata,
  output logic                   pready,
  output logic                   pslverr
);

  localparam int unsigned NBYTES = DATAWIDTH / 8;
  localparam int unsigned OFFW   = $clog2(NBYTES);
  localparam int unsigned RIW    = $clog2(DEPTH);
  localparam int unsigned CW     = 4;
  localparam logic [ADDRWIDTH-1:0] ALIGN_MASK = ADDRWIDTH'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, SETUP_SEEN, ACCESS} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic                 write_q, write_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic [NBYTES-1:0]    strb_q, strb_d, strb_in_c;
  logic                 pready_q, pready_d;
  logic                 pslverr_q, pslverr_d;
  logic [DATAWIDTH-1:0] prdata_q, prdata_d;
  logic [DATAWIDTH-1:0] regs_q [DEPTH];

  logic [ADDRWIDTH-1:0] sel_addr_c, idx_c;
  logic                 sel_write_c, err_c, wr_en_c, load_resp_c;
  logic [RIW-1:0]       ridx_c;
  logic [DATAWIDTH-1:0] rdval_c, wmask_c;

`ifdef APB_PSTRB_EN
  assign strb_in_c = pstrb;
`else
  assign strb_in_c = '1;
`endif

  // Decode from the bus on the setup edge, from the latched transfer afterwards.
  always_comb begin
    sel_addr_c  = (state_q == IDLE) ? paddr  : addr_q;
    sel_write_c = (state_q == IDLE) ? pwrite : write_q;
    idx_c       = sel_addr_c >> OFFW;
    ridx_c      = RIW'(idx_c);
    err_c       = (idx_c >= ADDRWIDTH'(DEPTH)) ||
                  ((sel_addr_c & ALIGN_MASK) != '0) ||
                  (sel_write_c && (idx_c == '0));
    rdval_c     = (idx_c == '0) ? ID : regs_q[ridx_c];
    for (int unsigned b = 0; b < NBYTES; b++) begin
      wmask_c[b*8 +: 8] = {8{strb_q[b]}};
    end
  end

  // Transfer FSM: next state, wait counter and registered response.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    pready_d    = pready_q;
    pslverr_d   = pslverr_q;
    prdata_d    = prdata_q;
    wr_en_c     = 1'b0;
    load_resp_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        pready_d  = 1'b0;
        pslverr_d = 1'b0;
        prdata_d  = '0;
        if (psel && !penable) begin
          state_d     = SETUP_SEEN;
          addr_d      = paddr;
          write_d     = pwrite;
          wdata_d     = pwdata;
          strb_d      = strb_in_c;
          cnt_d       = CW'(WAIT);
          load_resp_c = (WAIT == 0);
        end
      end
      SETUP_SEEN, ACCESS: begin
        if (!psel) begin
          state_d   = IDLE;
          cnt_d     = '0;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else if (penable && pready_q) begin
          state_d   = IDLE;
          cnt_d     = '0;
          wr_en_c   = write_q && !err_c;
          pready_d  = 1'b0;
          pslverr_d = 1'b0;
          prdata_d  = '0;
        end else begin
          state_d = ACCESS;
          if (!pready_q) begin
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            load_resp_c = (cnt_q <= CW'(1));
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_resp_c) begin
      pready_d  = 1'b1;
      pslverr_d = err_c;
      prdata_d  = (err_c || sel_write_c) ? '0 : rdval_c;
    end
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      prdata_q  <= prdata_d;
    end
  end

  // Register file; entry 0 is never written since index 0 reads back ID.
  always_ff @(posedge pclk) begin
    if (preset) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs_q[i] <= '0;
    end else if (wr_en_c) begin
      regs_q[ridx_c] <= (regs_q[ridx_c] & ~wmask_c) | (wdata_q & wmask_c);
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule
